// File: rtl/bg_line_fetch_if.sv
// bg_line_fetch_if: DDR read channel and line-buffer write port of the background fetcher
interface bg_line_fetch_if #(
    parameter int ADDR_W = 28,
    parameter int BW     = 8
);
    logic              ddr_req;
    logic [ADDR_W-1:0] ddr_addr;
    logic              ddr_ready;
    logic              buf_we;
    logic [BW:0]       buf_addr;
    modport master (output ddr_req, ddr_addr, buf_we, buf_addr, input ddr_ready);
    modport slave  (input ddr_req, ddr_addr, buf_we, buf_addr, output ddr_ready);
endinterface

// File: rtl/bg_line_fetch.sv
// bg_line_fetch: two-bank line prefetch scheduler between DDR reads and the background display
module bg_line_fetch #(
    parameter int LINE_WORDS   = 256,
    parameter int FRAME_LINES  = 224,
    parameter int BASE_ADDR    = 0,
    parameter int STRIDE_BYTES = 1024,
    parameter int ADDR_W       = 28
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    bg_line_fetch_if.master bus,
    input  logic            enable,
    input  logic            frame_start,
    input  logic            line_done,
    output logic            disp_bank,
    output logic            line_ready,
    output logic            busy,
    output logic            underrun,
    output logic [9:0]      line_cnt
);
    localparam int BW = $clog2(LINE_WORDS);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [9:0] LINES = 10'(FRAME_LINES);

    logic [1:0]        state, state_n;
    logic [1:0]        bank_full, bank_full_n;
    logic              fill_bank, fill_bank_n;
    logic [BW-1:0]     word_idx, word_idx_n;
    logic [ADDR_W-1:0] line_addr, line_addr_n;
    logic [9:0]        line_cnt_n;
    logic              disp_bank_n, underrun_n;
    logic              pending_swap, pending_n;
    logic              start, last, in_flight;

    assign start      = enable && line_cnt < LINES && !bank_full[fill_bank];
    assign last       = &word_idx;
    assign in_flight  = state == REQ || ((state == WAIT || state == DRAIN) && !bus.ddr_ready);
    assign bus.buf_we = state == WAIT && bus.ddr_ready && !frame_start;
    assign bus.buf_addr = {fill_bank, word_idx};
    assign line_ready = bank_full[disp_bank];

    // next-state: word sequencing, bank hand-over to the display, then frame restart overriding all
    always_comb begin
        state_n     = state;
        bank_full_n = bank_full;
        fill_bank_n = fill_bank;
        word_idx_n  = word_idx;
        line_addr_n = line_addr;
        line_cnt_n  = line_cnt;
        disp_bank_n = disp_bank;
        underrun_n  = underrun;
        pending_n   = pending_swap;
        if (state == IDLE)
            state_n = start ? REQ : IDLE;
        else if (state == REQ)
            state_n = WAIT;
        else if (state == WAIT && bus.ddr_ready) begin
            state_n    = last ? IDLE : REQ;
            word_idx_n = word_idx + 1'b1;
            if (last) begin
                bank_full_n[fill_bank] = 1'b1;
                fill_bank_n = ~fill_bank;
                line_addr_n = line_addr + ADDR_W'(STRIDE_BYTES);
                line_cnt_n  = line_cnt + 10'd1;
            end
        end else if (state == DRAIN && bus.ddr_ready)
            state_n = IDLE;
        if ((line_done || pending_swap) && bank_full_n[~disp_bank]) begin
            bank_full_n[disp_bank] = 1'b0;
            disp_bank_n = ~disp_bank;
            pending_n   = 1'b0;
        end else if (line_done && line_cnt < LINES) begin
            underrun_n = 1'b1;
            pending_n  = 1'b1;
        end
        if (frame_start) begin
            state_n     = in_flight ? DRAIN : (enable && FRAME_LINES > 0) ? REQ : IDLE;
            bank_full_n = '0;
            fill_bank_n = 1'b0;
            word_idx_n  = '0;
            line_addr_n = BASE;
            line_cnt_n  = '0;
            disp_bank_n = 1'b0;
            underrun_n  = 1'b0;
            pending_n   = 1'b0;
        end
    end

    // state and registered outputs; the request address is latched on entry to REQ
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bank_full    <= '0;
            fill_bank    <= 1'b0;
            word_idx     <= '0;
            line_addr    <= BASE;
            line_cnt     <= '0;
            disp_bank    <= 1'b0;
            underrun     <= 1'b0;
            pending_swap <= 1'b0;
            busy         <= 1'b0;
            bus.ddr_req  <= 1'b0;
            bus.ddr_addr <= BASE;
        end else begin
            state        <= state_n;
            bank_full    <= bank_full_n;
            fill_bank    <= fill_bank_n;
            word_idx     <= word_idx_n;
            line_addr    <= line_addr_n;
            line_cnt     <= line_cnt_n;
            disp_bank    <= disp_bank_n;
            underrun     <= underrun_n;
            pending_swap <= pending_n;
            busy         <= state_n != IDLE;
            bus.ddr_req  <= state_n == REQ;
            if (state_n == REQ)
                bus.ddr_addr <= line_addr_n + (ADDR_W'(word_idx_n) << 2);
        end
    end
endmodule

// File: tb/tb_bg_line_fetch.sv
// tb_bg_line_fetch: DDR responder with write scoreboard plus table-driven frame sequencing checks
module tb_bg_line_fetch;
    localparam int LW = 4, FL = 3, AW = 28, BW = 2;
    typedef struct { logic we; logic [BW:0] addr; } sb_t;
    typedef struct { logic ld; logic disp; logic rdy; logic [9:0] cnt; logic und; } vec_t;

    logic clk_sys = 0, reset_n = 1, enable = 0, frame_start = 0, line_done = 0;
    logic disp_bank, line_ready, busy, underrun;
    logic [9:0] line_cnt;
    int n_pass = 0, n_chk = 0, cyc = 0, n_req = 0, rdy_cyc = -100;
    int m_line = 0, m_word = 0;
    logic drop = 0;
    sb_t exp_q[$];
    vec_t tbl[4];

    bg_line_fetch_if #(.ADDR_W(AW), .BW(BW)) bus ();

    bg_line_fetch #(
        .LINE_WORDS(LW), .FRAME_LINES(FL), .BASE_ADDR(0), .STRIDE_BYTES(1024), .ADDR_W(AW)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus.master),
        .enable(enable), .frame_start(frame_start), .line_done(line_done),
        .disp_bank(disp_bank), .line_ready(line_ready), .busy(busy),
        .underrun(underrun), .line_cnt(line_cnt)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ddr_req"}, bus.ddr_req, 0);
        chk({tag, "_ddr_addr"}, bus.ddr_addr, 0);
        chk({tag, "_buf_we"}, bus.buf_we, 0);
        chk({tag, "_buf_addr"}, bus.buf_addr, 0);
        chk({tag, "_disp_bank"}, disp_bank, 0);
        chk({tag, "_line_ready"}, line_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_line_cnt"}, line_cnt, 0);
    endtask

    task automatic pulse_fs();
        frame_start = 1;
        m_line = 0;
        m_word = 0;
        rdy_cyc = -100;
        @(posedge clk_sys);
        #1 frame_start = 0;
    endtask

    task automatic pulse_ld();
        line_done = 1;
        @(posedge clk_sys);
        #1 line_done = 0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        do begin
            @(posedge clk_sys);
            #1 n++;
        end while (!bus.ddr_req && n < 200);
        chk(name, bus.ddr_req, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0, q = 0;
        while (q < 3 && n < 500) begin
            @(posedge clk_sys);
            #1 n++;
            q = busy ? 0 : q + 1;
        end
        chk(name, q, 3);
    endtask

    // DDR responder: L = 2, checks request address against the bench's line/word model
    initial begin
        logic [AW-1:0] a;
        bus.ddr_ready = 0;
        @(posedge clk_sys);
        forever begin
            #1;
            if (bus.ddr_req) begin
                n_req++;
                a = AW'(m_line * 1024 + m_word * 4);
                chk("req_addr", bus.ddr_addr, a);
                repeat (2) @(posedge clk_sys);
                #1 bus.ddr_ready = 1;
                if (!drop && m_line == 1 && m_word == LW - 1) rdy_cyc = cyc;
                exp_q.push_back('{!drop, {m_line[0], m_word[1:0]}});
                if (!drop) begin
                    m_word = (m_word + 1) % LW;
                    if (m_word == 0) m_line++;
                end
                drop = 0;
                @(posedge clk_sys);
                #1 bus.ddr_ready = 0;
            end else
                @(posedge clk_sys);
        end
    end

    // scoreboard: each ready cycle pops the expected write; writes outside ready cycles are errors
    initial begin
        sb_t e;
        forever begin
            @(negedge clk_sys);
            if (bus.ddr_ready) begin
                if (exp_q.size() == 0) chk("sb_pop", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("buf_we", bus.buf_we, e.we);
                    if (e.we) chk("buf_addr", bus.buf_addr, e.addr);
                end
            end else if (bus.buf_we)
                chk("stray_we", bus.buf_we, 0);
        end
    end

    initial begin
        int n, k;
        tbl[0] = '{1'b0, 1'b0, 1'b1, 10'd2, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 10'd3, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 10'd3, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 10'd3, 1'b0};
        #1 reset_n = 0;
        #6 chk_reset_outs("rst");
        #16 reset_n = 1;
        @(posedge clk_sys);
        #1 chk("idle_no_fs", busy, 0);
        enable = 1;
        pulse_fs();
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].ld) begin
                pulse_ld();
                chk("ld_disp", disp_bank, tbl[i].disp);
            end
            wait_idle("tbl_idle");
            chk("tbl_disp", disp_bank, tbl[i].disp);
            chk("tbl_ready", line_ready, tbl[i].rdy);
            chk("tbl_cnt", line_cnt, tbl[i].cnt);
            chk("tbl_und", underrun, tbl[i].und);
            if (i == 1) chk("frame_reqs", n_req, 12);
        end
        pulse_fs();
        n = 0;
        while (!line_ready && n < 100) begin
            @(posedge clk_sys);
            #1 n++;
        end
        chk("first_line_lat", n, 12);
        repeat (3) @(posedge clk_sys);
        #1 pulse_ld();
        chk("und_set", underrun, 1);
        chk("und_disp_hold", disp_bank, 0);
        n = 0;
        while (!disp_bank && n < 100) begin
            @(posedge clk_sys);
            #1 n++;
        end
        chk("pend_swap_cyc", cyc, rdy_cyc + 1);
        chk("pend_ready", line_ready, 1);
        chk("und_sticky", underrun, 1);
        wait_req("drain_req");
        @(posedge clk_sys);
        #1 drop = 1;
        pulse_fs();
        chk("fs_und_clr", underrun, 0);
        wait_req("restart_req");
        chk("restart_addr", bus.ddr_addr, 0);
        chk("restart_baddr", bus.buf_addr, 0);
        wait_req("mid_req");
        #2 drop = 1;
        reset_n = 0;
        m_line = 0;
        m_word = 0;
        #1 chk_reset_outs("async");
        repeat (5) @(posedge clk_sys);
        #3 reset_n = 1;
        wait_req("post_rst_req");
        chk("post_rst_addr", bus.ddr_addr, 0);
        wait_idle("fill_idle");
        enable = 0;
        pulse_fs();
        k = n_req;
        repeat (9) @(posedge clk_sys);
        #1 chk("en_low_noreq", n_req, k);
        chk("en_low_busy", busy, 0);
        chk("en_low_cnt", line_cnt, 0);
        enable = 1;
        @(posedge clk_sys);
        #1 chk("en_rise_req", bus.ddr_req, 1);
        chk("en_rise_addr", bus.ddr_addr, 0);
        wait_idle("final_idle");
        chk("final_cnt", line_cnt, 2);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
